// File: rtl/rc5_key_expand.sv
// RC5 key-schedule engine: loads key words into L, builds the round-key table S and serves it on two
// registered read ports. Define KEY_CLEAR_EN to wipe L after mixing (adds the CLEAR state).
module rc5_key_expand #(
    parameter int W = 32,
    parameter int R = 12,
    parameter int B = 16,
    localparam int C         = (B == 0) ? 1 : (8 * B + W - 1) / W,
    localparam int T         = 2 * (R + 1),
    localparam int N         = 3 * ((T > C) ? T : C),
    localparam int T_LENGTH  = $clog2(T),
    localparam int C_LENGTH  = (C > 1) ? $clog2(C) : 1,
    localparam int ROT_VALUE = $clog2(W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iKey_we,
    input  logic [C_LENGTH-1:0] iKey_addr,
    input  logic [W-1:0]        iKey_word,
    input  logic                iStart,
    input  logic [T_LENGTH-1:0] iS_address1,
    input  logic [T_LENGTH-1:0] iS_address2,
    output logic [W-1:0]        oS_sub_i1,
    output logic [W-1:0]        oS_sub_i2,
    output logic                oBusy,
    output logic                oDone
);

    localparam int K_LENGTH = $clog2(N);

    localparam logic [63:0] P64 = (W == 16) ? 64'h0000_0000_0000_B7E1 :
                                  (W == 32) ? 64'h0000_0000_B7E1_5163 : 64'hB7E1_5162_8AED_2A6B;
    localparam logic [63:0] Q64 = (W == 16) ? 64'h0000_0000_0000_9E37 :
                                  (W == 32) ? 64'h0000_0000_9E37_79B9 : 64'h9E37_79B9_7F4A_7C15;
    localparam logic [W-1:0] P = P64[W-1:0];
    localparam logic [W-1:0] Q = Q64[W-1:0];

    localparam logic [T_LENGTH-1:0] T_LAST = T_LENGTH'(T - 1);
    localparam logic [T_LENGTH-1:0] T_ONE  = T_LENGTH'(1);
    localparam logic [C_LENGTH-1:0] C_LAST = C_LENGTH'(C - 1);
    localparam logic [C_LENGTH-1:0] C_ONE  = C_LENGTH'(1);
    localparam logic [K_LENGTH-1:0] K_LAST = K_LENGTH'(N - 1);
    localparam logic [K_LENGTH-1:0] K_ONE  = K_LENGTH'(1);

    typedef enum logic [2:0] {IDLE, INIT_S, MIX_A, MIX_B, CLEAR, DONE} state_t;

    state_t              state, stateNext;
    logic [W-1:0]        sArr [T];
    logic [W-1:0]        lArr [C];
    logic [W-1:0]        regA, regB;
    logic [T_LENGTH-1:0] idxI, idxPrev;
    logic [C_LENGTH-1:0] idxJ;
    logic [K_LENGTH-1:0] idxK;
    logic                pendWe;
    logic [C_LENGTH-1:0] pendAddr;
    logic [W-1:0]        pendWord;
    logic                keyWrOk;
    logic [W-1:0]        initVal, mixAVal, mixBAmt, mixBVal;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [ROT_VALUE-1:0] s);
        logic [2*W-1:0] t;
        t = {x, x} << s;
        return t[2*W-1:W];
    endfunction

    assign keyWrOk = iKey_we && ({1'b0, iKey_addr} < (C_LENGTH + 1)'(C));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:   if (iStart) stateNext = INIT_S;
            INIT_S: if (idxI == T_LAST) stateNext = MIX_A;
            MIX_A:  stateNext = MIX_B;
            MIX_B: begin
                if (idxK == K_LAST) begin
`ifdef KEY_CLEAR_EN
                    stateNext = CLEAR;
`else
                    stateNext = DONE;
`endif
                end else begin
                    stateNext = MIX_A;
                end
            end
`ifdef KEY_CLEAR_EN
            CLEAR:  if (idxJ == C_LAST) stateNext = DONE;
`endif
            DONE:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        idxPrev = (idxI == '0) ? '0 : idxI - T_ONE;
        initVal = (idxI == '0) ? P : sArr[idxPrev] + Q;
        mixAVal = rotl(sArr[idxI] + regA + regB, ROT_VALUE'(3));
        mixBAmt = regA + regB;
        mixBVal = rotl(lArr[idxJ] + mixBAmt, mixBAmt[ROT_VALUE-1:0]);
    end

    // NOTE: S and L must read as zero after reset, so they are reset register arrays rather than RAM.
    // NOTE: all state here uses non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < T; t++) sArr[t] <= '0;
            for (int c = 0; c < C; c++) lArr[c] <= '0;
            regA      <= '0;
            regB      <= '0;
            idxI      <= '0;
            idxJ      <= '0;
            idxK      <= '0;
            pendWe    <= 1'b0;
            pendAddr  <= '0;
            pendWord  <= '0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oS_sub_i1 <= '0;
            oS_sub_i2 <= '0;
        end else begin
            oS_sub_i1 <= ({1'b0, iS_address1} < (T_LENGTH + 1)'(T)) ? sArr[iS_address1] : '0;
            oS_sub_i2 <= ({1'b0, iS_address2} < (T_LENGTH + 1)'(T)) ? sArr[iS_address2] : '0;

            case (state)
                IDLE: begin
                    if (iStart) begin
                        regA  <= '0;
                        regB  <= '0;
                        idxI  <= '0;
                        idxJ  <= '0;
                        idxK  <= '0;
                        oDone <= 1'b0;
                        oBusy <= 1'b1;
                        // A key word arriving with iStart is held back so this run mixes the old L.
                        if (keyWrOk) begin
                            pendWe   <= 1'b1;
                            pendAddr <= iKey_addr;
                            pendWord <= iKey_word;
                        end
                    end else if (keyWrOk) begin
                        lArr[iKey_addr] <= iKey_word;
                    end
                end
                INIT_S: begin
                    sArr[idxI] <= initVal;
                    idxI       <= (idxI == T_LAST) ? '0 : idxI + T_ONE;
                end
                MIX_A: begin
                    sArr[idxI] <= mixAVal;
                    regA       <= mixAVal;
                end
                MIX_B: begin
                    lArr[idxJ] <= mixBVal;
                    regB       <= mixBVal;
                    idxI       <= (idxI == T_LAST) ? '0 : idxI + T_ONE;
                    idxJ       <= (idxJ == C_LAST) ? '0 : idxJ + C_ONE;
                    idxK       <= idxK + K_ONE;
`ifdef KEY_CLEAR_EN
                    if (idxK == K_LAST) idxJ <= '0;
`endif
                end
`ifdef KEY_CLEAR_EN
                CLEAR: begin
                    lArr[idxJ] <= '0;
                    idxJ       <= (idxJ == C_LAST) ? '0 : idxJ + C_ONE;
                end
`endif
                DONE: begin
                    oDone <= 1'b1;
                    oBusy <= 1'b0;
                    if (pendWe) begin
                        lArr[pendAddr] <= pendWord;
                        pendWe         <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/rc5_key_expand.md
# rc5_key_expand

RC5 key-schedule engine: loads a secret key as W-bit words into an internal L array, builds the round-key table S[0..T-1] (T = 2(R+1)) with the standard RC5 initialise-and-mix algorithm, and then serves S through two read ports. It sits directly upstream of the decipher stage. Its read ports connect to the decipher's S address outputs and S data inputs, and its oDone gates the decipher's iStart.

## Interface
Parameters:
- W, 32: word width in bits. Legal values are 16, 32 and 64.
- R, 12: number of rounds.
- B, 16: key length in bytes.
- Derived: C = max(1, ceil(8B/W)) key words; T = 2(R+1); N = 3·max(T,C) mix iterations; T_LENGTH = $clog2(T); C_LENGTH = $clog2(C) (minimum 1); ROT_VALUE = $clog2(W).

Ports:
- clk, input, 1: sole clock. Everything is rising-edge.
- rst, input, 1: synchronous reset, active-high.
- iKey_we, input, 1: key word write strobe.
- iKey_addr, input, C_LENGTH: key word index j.
- iKey_word, input, W: L[j] value, already little-endian packed.
- iStart, input, 1: begin expansion.
- iS_address1, input, T_LENGTH: S read address, port 1.
- iS_address2, input, T_LENGTH: S read address, port 2.
- oS_sub_i1, output, W: registered S[iS_address1].
- oS_sub_i2, output, W: registered S[iS_address2].
- oBusy, output, 1: expansion in progress.
- oDone, output, 1: S table valid.

## Operation
Constants P and Q are selected by W:
- W=16: P=B7E1, Q=9E37.
- W=32: P=B7E15163, Q=9E3779B9.
- W=64: P=B7E151628AED2A6B, Q=9E3779B97F4A7C15.

All arithmetic is modulo 2^W. A rotate amount uses only the low ROT_VALUE bits of its operand.

State machine:
- IDLE:
  - A key write to L[iKey_addr] is accepted only here, and only when iKey_addr < C.
  - iStart moves to INIT_S. It also clears oDone and zeroes A, B, i, j and k.
- INIT_S: one S entry per cycle. S[0]=P, then S[i]=S[i-1]+Q, for i=0..T-1. After T cycles go to MIX_A.
- MIX_A: A ← S[i] ← rotl(S[i]+A+B, 3).
- MIX_B:
  - B ← L[j] ← rotl(L[j]+A+B, A+B).
  - i ← (i+1) mod T; j ← (j+1) mod C; k ← k+1.
  - If k = N-1 before the increment, go to CLEAR (when KEY_CLEAR_EN is defined) or to DONE. Otherwise go back to MIX_A.
- CLEAR: zeroes one L word per cycle, C cycles in total, then DONE.
- DONE: sets oDone=1 and returns to IDLE. oDone stays 1 until the next accepted iStart or rst.

Other behaviour:
- oBusy = 1 in INIT_S, MIX_A, MIX_B and CLEAR.
- While busy, iStart and iKey_we are ignored.
- Reads are allowed in every state. While busy they return the in-progress S contents.
- A read address ≥ T returns 0.
- Reset clears all of S and L to 0.

## Timing
- Reset values:
  - oS_sub_i1 = 0, oS_sub_i2 = 0, oBusy = 0, oDone = 0.
  - state = IDLE; A, B, i, j and k = 0.
- Read latency is 1 cycle: the address is sampled on edge n and the data is valid after edge n.
- Key write: L is updated on the edge that samples iKey_we.
- oDone latency, counted in edges from the edge that samples iStart:
  - without CLEAR: T + 2N + 1;
  - with CLEAR: T + 2N + C + 1.
  - For the defaults this is 26 + 156 + 1 = 183, or 187 with CLEAR.
- oBusy rises on the edge that samples iStart and falls on the same edge that raises oDone.
- rst mid-expansion: on the next edge the block is in IDLE with S and L zeroed and oDone = 0.
- iStart and iKey_we in the same IDLE cycle: the write and the start both take effect, and the expansion uses the old L[iKey_addr].

## Configuration
- KEY_CLEAR_EN defined:
  - The CLEAR state is present and L is wiped after mixing.
  - Post-done key readback via iKey_addr is not provided, and L reads 0 internally.
- KEY_CLEAR_EN undefined:
  - MIX_B goes straight to DONE.
  - L keeps the mixed key words, so a repeated iStart without reloading the key produces a different S.

## Test plan
- Reset, then read addresses 0 and 25 → oS_sub_i1 = 0, oS_sub_i2 = 0, oDone = 0, oBusy = 0.
- Load a zero key (4 writes), pulse iStart, sample S[0], S[1] and S[2] at edge 27 → B7E15163, 5618CB1C, F45044D5. Also check oBusy = 1.
- Zero key expansion, count edges → oDone rises at edge 183 (187 with KEY_CLEAR_EN). Then connect the decipher with iA = EEDBA521, iB = 6D8F4B15 → decipher output A = 0, B = 0.
- Pulse iStart and iKey_we (addr 1, data FFFFFFFF) during MIX → both ignored. The result must match the zero-key run, and oDone must still rise at edge 183.
- Assert rst at edge 100 of an expansion → next edge: oBusy = 0, oDone = 0, S[0] reads 0. A fresh run afterwards completes normally.
- Read address 26 or 31 after done → 0. Addresses 24 and 25 read through both ports on the same cycle → identical data on both ports.
